rect_draw_engine: RTL and testbench



---
 rtl/rect_draw_engine.sv | 143 ++++++++++++++
 tb/tb_rect_draw_engine.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: emits one pixel per valid/ready handshake in raster order, filled or outline.
// Optional clipping against SCREEN_W/SCREEN_H is enabled by defining RECT_DRAW_CLIP_EN.
module rect_draw_engine #(
    parameter int unsigned nX       = 10,
    parameter int unsigned nY       = 9,
    parameter int unsigned COLOR_W  = 9,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               start,
    input  logic [nX-1:0]      x0,
    input  logic [nY-1:0]      y0,
    input  logic [nX-1:0]      w,
    input  logic [nY-1:0]      h,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               outline,
    output logic [nX-1:0]      pix_x,
    output logic [nY-1:0]      pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               done,
    output logic [nX+nY-1:0]   px_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [nX-1:0]      x0_q, x0_d, w_q, w_d, xc_q, xc_d;
    logic [nY-1:0]      y0_q, y0_d, h_q, h_d, yc_q, yc_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               outline_q, outline_d;
    logic [nX+nY-1:0]   cnt_q, cnt_d;

    logic clip, accept, advance;
    logic last_x, last_y, first_y;

`ifdef RECT_DRAW_CLIP_EN
    localparam logic [nX:0] SCR_W = (nX+1)'(SCREEN_W);
    localparam logic [nY:0] SCR_H = (nY+1)'(SCREEN_H);
    logic [nX:0] sum_x;
    logic [nY:0] sum_y;

    assign sum_x = {1'b0, x0_q} + {1'b0, xc_q};
    assign sum_y = {1'b0, y0_q} + {1'b0, yc_q};
    assign clip  = (state_q == S_RUN) && ((sum_x >= SCR_W) || (sum_y >= SCR_H));
    assign pix_x = sum_x[nX-1:0];
    assign pix_y = sum_y[nY-1:0];
`else
    assign clip  = 1'b0;
    assign pix_x = x0_q + xc_q;
    assign pix_y = y0_q + yc_q;
`endif

    // pix_valid depends only on registered state, so ready never feeds back into it
    assign pix_valid = (state_q == S_RUN) && !clip;
    assign pix_color = color_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign px_count  = cnt_q;

    assign accept  = pix_valid && pix_ready;
    assign advance = accept || clip;
    assign last_x  = (xc_q == w_q - nX'(1));
    assign last_y  = (yc_q == h_q - nY'(1));
    assign first_y = (yc_q == '0);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            xc_q      <= '0;
            yc_q      <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            w_q       <= w_d;
            h_q       <= h_d;
            xc_q      <= xc_d;
            yc_q      <= yc_d;
            color_q   <= color_d;
            outline_q <= outline_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        w_d       = w_q;
        h_d       = h_q;
        xc_d      = xc_q;
        yc_d      = yc_q;
        color_d   = color_q;
        outline_d = outline_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d      = x0;
                    y0_d      = y0;
                    w_d       = w;
                    h_d       = h;
                    color_d   = color_in;
                    outline_d = outline;
                    xc_d      = '0;
                    yc_d      = '0;
                    cnt_d     = '0;
                    state_d   = ((w == '0) || (h == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) cnt_d = cnt_q + (nX+nY)'(1);
                if (advance) begin
                    if (last_x) begin
                        xc_d = '0;
                        if (last_y) state_d = S_DONE;
                        else        yc_d = yc_q + nY'(1);
                    // interior outline rows skip straight to the right edge
                    end else if (outline_q && (xc_q == '0) && !first_y && !last_y) begin
                        xc_d = w_q - nX'(1);
                    end else begin
                        xc_d = xc_q + nX'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Self-checking bench for rect_draw_engine: expected pixels queued per command, popped on each handshake.
module tb_rect_draw_engine;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } pix_t;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  x0 = '0;
    logic [8:0]  y0 = '0;
    logic [9:0]  w = '0;
    logic [8:0]  h = '0;
    logic [8:0]  color_in = '0;
    logic        outline = 1'b0;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [8:0]  pix_color;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [18:0] px_count;

    int checks = 0;
    int errors = 0;
    pix_t exp_q[$];

    rect_draw_engine #(.nX(10), .nY(9), .COLOR_W(9), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color_in(color_in), .outline(outline), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done), .px_count(px_count)
    );

    always #5 Clock = ~Clock;

    // Called at a falling edge: drives one start cycle and returns at the falling edge of cycle 1.
    task automatic issue(input logic [9:0] ix, input logic [8:0] iy, input logic [9:0] iw,
                         input logic [8:0] ih, input logic [8:0] col, input logic ol);
        x0 = ix; y0 = iy; w = iw; h = ih; color_in = col; outline = ol;
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        #1;
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", pix_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        checks++; if (px_count !== 19'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", px_count); end
        checks++; if ({pix_x, pix_y, pix_color} !== 28'd0) begin
            errors++; $display("FAIL reset_pix: got x=%0d y=%0d c=%h, expected all 0", pix_x, pix_y, pix_color);
        end
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy got %b, expected 0", busy); end
    endtask

    task automatic test_fill();
        pix_t p;
        int npix = 0;
        int done_cyc = -1;
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) begin p.x = 10'(10 + c); p.y = 9'(20 + r); exp_q.push_back(p); end
        pix_ready = 1'b1;
        issue(10'd10, 9'd20, 10'd3, 9'd2, 9'h1A5, 1'b0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL fill_extra: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_color} !== {p.x, p.y, 9'h1A5}) begin
                        errors++; $display("FAIL fill_pix: got (%0d,%0d,%h), expected (%0d,%0d,1a5)", pix_x, pix_y, pix_color, p.x, p.y);
                    end
                end
                checks++; if (cyc != npix + 1) begin errors++; $display("FAIL fill_timing: pixel %0d in cycle %0d, expected cycle %0d", npix, cyc, npix + 1); end
                npix++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cyc == 8) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy8: got %b, expected 0", busy); end
            end
            @(negedge Clock);
        end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL fill_done: got cycle %0d, expected 7", done_cyc); end
        checks++; if (npix != 6 || exp_q.size() != 0) begin errors++; $display("FAIL fill_num: got %0d pixels, expected 6", npix); end
        checks++; if (px_count !== 19'd6) begin errors++; $display("FAIL fill_count: got %0d, expected 6", px_count); end
    endtask

    task automatic test_outline();
        pix_t p;
        int npix = 0;
        int done_cyc = -1;
        exp_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (r == 0 || r == 3 || c == 0 || c == 3) begin p.x = 10'(c); p.y = 9'(r); exp_q.push_back(p); end
        pix_ready = 1'b1;
        issue(10'd0, 9'd0, 10'd4, 9'd4, 9'h0F0, 1'b1);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (pix_valid && pix_ready) begin
                checks++;
                if (pix_x >= 10'd1 && pix_x <= 10'd2 && pix_y >= 9'd1 && pix_y <= 9'd2) begin
                    errors++; $display("FAIL outline_interior: got (%0d,%0d), expected edge pixel", pix_x, pix_y);
                end else if (exp_q.size() == 0) begin
                    errors++; $display("FAIL outline_extra: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_color} !== {p.x, p.y, 9'h0F0}) begin
                        errors++; $display("FAIL outline_pix: got (%0d,%0d,%h), expected (%0d,%0d,0f0)", pix_x, pix_y, pix_color, p.x, p.y);
                    end
                end
                npix++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge Clock);
        end
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL outline_done: got cycle %0d, expected 13", done_cyc); end
        checks++; if (npix != 12 || exp_q.size() != 0) begin errors++; $display("FAIL outline_num: got %0d pixels, expected 12", npix); end
        checks++; if (px_count !== 19'd12) begin errors++; $display("FAIL outline_count: got %0d, expected 12", px_count); end
    endtask

    task automatic test_backpressure();
        pix_t p;
        int npix = 0;
        int done_cyc = -1;
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) begin p.x = 10'(10 + c); p.y = 9'(20 + r); exp_q.push_back(p); end
        pix_ready = 1'b1;
        issue(10'd10, 9'd20, 10'd3, 9'd2, 9'h033, 1'b0);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc >= 2 && cyc <= 5) begin
                checks++;
                if (pix_valid !== 1'b1 || pix_x !== 10'd11 || pix_y !== 9'd20 || pix_color !== 9'h033) begin
                    errors++; $display("FAIL bp_hold: cycle %0d got v=%b (%0d,%0d,%h), expected v=1 (11,20,033)", cyc, pix_valid, pix_x, pix_y, pix_color);
                end
            end
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y} !== {p.x, p.y}) begin
                        errors++; $display("FAIL bp_pix: got (%0d,%0d), expected (%0d,%0d)", pix_x, pix_y, p.x, p.y);
                    end
                end
                npix++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge Clock);
            pix_ready = !(cyc + 1 >= 2 && cyc + 1 <= 4);
        end
        pix_ready = 1'b1;
        checks++; if (done_cyc != 10) begin errors++; $display("FAIL bp_done: got cycle %0d, expected 10", done_cyc); end
        checks++; if (npix != 6 || exp_q.size() != 0) begin errors++; $display("FAIL bp_num: got %0d pixels, expected 6", npix); end
        checks++; if (px_count !== 19'd6) begin errors++; $display("FAIL bp_count: got %0d, expected 6", px_count); end
    endtask

    task automatic test_degenerate();
        int nvalid = 0;
        pix_ready = 1'b1;
        issue(10'd5, 9'd5, 10'd0, 9'd5, 9'h111, 1'b0);
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL degen_done: got done=%b busy=%b, expected 1 1", done, busy); end
        // start coinciding with done must be dropped
        x0 = 10'd1; y0 = 9'd1; w = 10'd2; h = 9'd1; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        for (int cyc = 2; cyc <= 6; cyc++) begin
            if (pix_valid) nvalid++;
            checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL degen_idle: cycle %0d got busy=%b done=%b, expected 0 0", cyc, busy, done); end
            @(negedge Clock);
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL degen_valid: got %0d valid cycles, expected 0", nvalid); end
        checks++; if (px_count !== 19'd0) begin errors++; $display("FAIL degen_count: got %0d, expected 0", px_count); end
    endtask

    task automatic test_back_to_back();
        pix_t p;
        int done_cyc = -1;
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin p.x = 10'(5 + c); p.y = 9'(5 + r); exp_q.push_back(p); end
        pix_ready = 1'b1;
        issue(10'd5, 9'd5, 10'd2, 9'd2, 9'h055, 1'b0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_color} !== {p.x, p.y, 9'h055}) begin
                        errors++; $display("FAIL b2b_pix: got (%0d,%0d,%h), expected (%0d,%0d,055)", pix_x, pix_y, pix_color, p.x, p.y);
                    end
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge Clock);
            if (cyc == 1) begin x0 = 10'd300; w = 10'd7; color_in = 9'h1EE; start = 1'b1; end
            else start = 1'b0;
        end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL b2b_done1: got cycle %0d, expected 5", done_cyc); end
        checks++; if (exp_q.size() != 0 || px_count !== 19'd4) begin errors++; $display("FAIL b2b_count1: got %0d, expected 4", px_count); end
        exp_q.delete();
        for (int r = 0; r < 3; r++) begin p.x = 10'd100; p.y = 9'(200 + r); exp_q.push_back(p); end
        done_cyc = -1;
        issue(10'd100, 9'd200, 10'd1, 9'd3, 9'h1FF, 1'b0);
        checks++; if (px_count !== 19'd0) begin errors++; $display("FAIL b2b_clear: got %0d, expected 0", px_count); end
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra2: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_color} !== {p.x, p.y, 9'h1FF}) begin
                        errors++; $display("FAIL b2b_pix2: got (%0d,%0d,%h), expected (%0d,%0d,1ff)", pix_x, pix_y, pix_color, p.x, p.y);
                    end
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge Clock);
        end
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL b2b_done2: got cycle %0d, expected 4", done_cyc); end
        checks++; if (exp_q.size() != 0 || px_count !== 19'd3) begin errors++; $display("FAIL b2b_count2: got %0d, expected 3", px_count); end
    endtask

    task automatic test_clip();
        pix_t p;
        int done_cyc = -1;
        int exp_n = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            p.x = 10'(638 + i); p.y = 9'd100;
`ifdef RECT_DRAW_CLIP_EN
            if (638 + i < 640) begin exp_q.push_back(p); exp_n++; end
`else
            exp_q.push_back(p); exp_n++;
`endif
        end
        pix_ready = 1'b1;
        issue(10'd638, 9'd100, 10'd4, 9'd1, 9'h0C3, 1'b0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL clip_extra: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y} !== {p.x, p.y}) begin
                        errors++; $display("FAIL clip_pix: got (%0d,%0d), expected (%0d,%0d)", pix_x, pix_y, p.x, p.y);
                    end
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge Clock);
        end
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL clip_done: got cycle %0d, expected 5", done_cyc); end
        checks++; if (exp_q.size() != 0 || px_count !== 19'(exp_n)) begin
            errors++; $display("FAIL clip_count: got %0d (left %0d), expected %0d", px_count, exp_q.size(), exp_n);
        end
    endtask

    task automatic test_reset_midop();
        pix_t p;
        int done_cyc = -1;
        pix_ready = 1'b1;
        issue(10'd50, 9'd60, 10'd5, 9'd5, 9'h0AA, 1'b0);
        repeat (6) @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        checks++; if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_out: got v=%b busy=%b done=%b, expected 0 0 0", pix_valid, busy, done);
        end
        checks++; if (px_count !== 19'd0) begin errors++; $display("FAIL midrst_count: got %0d, expected 0", px_count); end
        @(negedge Clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %b, expected 0", done); end
        Resetn = 1'b1;
        @(negedge Clock);
        exp_q.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin p.x = 10'(7 + c); p.y = 9'(8 + r); exp_q.push_back(p); end
        issue(10'd7, 9'd8, 10'd3, 9'd3, 9'h123, 1'b0);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (pix_valid && pix_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL midrst_extra: got (%0d,%0d), expected no pixel", pix_x, pix_y);
                end else begin
                    p = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_color} !== {p.x, p.y, 9'h123}) begin
                        errors++; $display("FAIL midrst_pix: got (%0d,%0d,%h), expected (%0d,%0d,123)", pix_x, pix_y, pix_color, p.x, p.y);
                    end
                end
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge Clock);
        end
        checks++; if (done_cyc != 10) begin errors++; $display("FAIL midrst_done: got cycle %0d, expected 10", done_cyc); end
        checks++; if (exp_q.size() != 0 || px_count !== 19'd9) begin errors++; $display("FAIL midrst_count2: got %0d, expected 9", px_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_outline();
        test_backpressure();
        test_degenerate();
        test_back_to_back();
        test_clip();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
